// File: rtl/branch_predictor_unit.sv
// ---------------------------------------------------------------------------
// branch_predictor_unit
//   Direct-mapped branch target buffer with per-entry saturating direction
//   counters and hit / misprediction statistics.
//
//   Optional feature macro: BPU_GSHARE_EN
//     defined   : an IDX-bit global history register is XOR-ed into the
//                 lookup and update indices (gshare); lookup_ghr = GHR.
//     undefined : plain PC indexing; lookup_ghr = 0, update_ghr ignored.
//
// Ports
//   clk              in   clock, all state on the rising edge
//   rst              in   asynchronous active-low reset
//   lookup_en        in   fetch PC valid, gates hit statistics only
//   lookup_pc        in   fetch PC
//   target_pc        out  predicted target (0 on miss)
//   valid            out  lookup hit
//   predicted_taken  out  hit and counter MSB set
//   lookup_ghr       out  history used for this lookup (travels to EX)
//   update           in   EX resolved a branch/jump
//   update_pc        in   PC of the resolved instruction
//   update_target    in   resolved target
//   update_taken     in   actual outcome
//   update_ghr       in   lookup_ghr carried with the instruction
//   mispredicted     in   EX redirect
//   invalidate_all   in   flush every entry (wins over a same-cycle update)
//   hit_count        out  saturating count of enabled lookup hits
//   mispredict_count out  saturating count of mispredictions
// ---------------------------------------------------------------------------
module branch_predictor_unit #(
    parameter  int ENTRIES  = 16,
    parameter  int XLEN     = 32,
    parameter  int CTR_BITS = 2,
    localparam int IDX      = $clog2(ENTRIES),
    localparam int TAG      = XLEN - IDX - 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lookup_en,
    input  logic [XLEN-1:0] lookup_pc,
    output logic [XLEN-1:0] target_pc,
    output logic            valid,
    output logic            predicted_taken,
    output logic [IDX-1:0]  lookup_ghr,
    input  logic            update,
    input  logic [XLEN-1:0] update_pc,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_taken,
    input  logic [IDX-1:0]  update_ghr,
    input  logic            mispredicted,
    input  logic            invalidate_all,
    output logic [31:0]     hit_count,
    output logic [31:0]     mispredict_count
);

    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

    function automatic logic [CTR_BITS-1:0] f_ctr_inc(input logic [CTR_BITS-1:0] c);
        return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
    endfunction

    function automatic logic [CTR_BITS-1:0] f_ctr_dec(input logic [CTR_BITS-1:0] c);
        return (c == '0) ? c : c - CTR_BITS'(1);
    endfunction

    function automatic logic [31:0] f_stat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    logic [ENTRIES-1:0]  r_valid;
    logic [TAG-1:0]      r_tag    [ENTRIES];
    logic [XLEN-1:0]     r_target [ENTRIES];
    logic [CTR_BITS-1:0] r_ctr    [ENTRIES];
    logic [31:0]         r_hit_cnt;
    logic [31:0]         r_mis_cnt;
    logic [IDX-1:0]      w_ghr;
    logic [IDX-1:0]      w_lidx;
    logic [IDX-1:0]      w_uidx;
    logic [TAG-1:0]      w_ltag;
    logic [TAG-1:0]      w_utag;
    logic                w_lhit;
    logic                w_uhit;
    logic                w_upd;
    logic                w_unused;

    // An invalidate in the same cycle discards the update entirely.
    assign w_upd  = update & ~invalidate_all;
    assign w_ltag = lookup_pc[XLEN-1:IDX+2];
    assign w_utag = update_pc[XLEN-1:IDX+2];

`ifdef BPU_GSHARE_EN
    logic [IDX-1:0] r_ghr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_ghr <= '0;
        else if (w_upd)
            r_ghr <= (r_ghr << 1) | IDX'(update_taken);
    end

    assign w_ghr  = r_ghr;
    assign w_lidx = lookup_pc[IDX+1:2] ^ r_ghr;
    assign w_uidx = update_pc[IDX+1:2] ^ update_ghr;
`else
    assign w_ghr  = '0;
    assign w_lidx = lookup_pc[IDX+1:2];
    assign w_uidx = update_pc[IDX+1:2];
`endif

    assign w_unused = ^{lookup_pc[1:0], update_pc[1:0], update_ghr};

    // Lookup reads registered state only, so a same-cycle update to the
    // same entry is seen one cycle later.
    assign w_lhit          = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);
    assign w_uhit          = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    assign valid           = w_lhit;
    assign predicted_taken = w_lhit & r_ctr[w_lidx][CTR_BITS-1];
    assign target_pc       = w_lhit ? r_target[w_lidx] : '0;
    assign lookup_ghr      = w_ghr;
    assign hit_count       = r_hit_cnt;
    assign mispredict_count = r_mis_cnt;

    // Control state: valid bits and direction counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++)
                r_ctr[i] <= '0;
        end else if (invalidate_all) begin
            r_valid <= '0;
        end else if (update) begin
            if (w_uhit)
                r_ctr[w_uidx] <= update_taken ? f_ctr_inc(r_ctr[w_uidx])
                                              : f_ctr_dec(r_ctr[w_uidx]);
            else if (update_taken) begin
                r_valid[w_uidx] <= 1'b1;
                r_ctr[w_uidx]   <= CTR_WEAK;
            end
        end
    end

    // Payload: a taken outcome either refreshes the target of the hitting
    // entry (tag unchanged) or allocates over the occupant.
    always_ff @(posedge clk) begin
        if (w_upd && update_taken) begin
            r_tag[w_uidx]    <= w_utag;
            r_target[w_uidx] <= update_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt <= '0;
            r_mis_cnt <= '0;
        end else begin
            if (lookup_en && w_lhit)
                r_hit_cnt <= f_stat_inc(r_hit_cnt);
            if (update && mispredicted)
                r_mis_cnt <= f_stat_inc(r_mis_cnt);
        end
    end

endmodule

// File: tb/tb_branch_predictor_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_unit
//   Table-driven bench with a scoreboard queue for branch_predictor_unit
//   (ENTRIES=16, XLEN=32, CTR_BITS=2). Each row is one cycle of stimulus and
//   the outputs expected before the following clock edge. With
//   BPU_GSHARE_EN defined a gshare-specific table replaces the default one.
// ---------------------------------------------------------------------------
module tb_branch_predictor_unit;

    logic        clk;
    logic        rst;
    logic        lookup_en;
    logic [31:0] lookup_pc;
    logic [31:0] target_pc;
    logic        valid;
    logic        predicted_taken;
    logic [3:0]  lookup_ghr;
    logic        update;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic [3:0]  update_ghr;
    logic        mispredicted;
    logic        invalidate_all;
    logic [31:0] hit_count;
    logic [31:0] mispredict_count;

    int n_total = 0;
    int n_pass  = 0;

    branch_predictor_unit #(.ENTRIES(16), .XLEN(32), .CTR_BITS(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .lookup_en       (lookup_en),
        .lookup_pc       (lookup_pc),
        .target_pc       (target_pc),
        .valid           (valid),
        .predicted_taken (predicted_taken),
        .lookup_ghr      (lookup_ghr),
        .update          (update),
        .update_pc       (update_pc),
        .update_target   (update_target),
        .update_taken    (update_taken),
        .update_ghr      (update_ghr),
        .mispredicted    (mispredicted),
        .invalidate_all  (invalidate_all),
        .hit_count       (hit_count),
        .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        le;
        logic [31:0] lpc;
        logic        up;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        utk;
        logic [3:0]  ughr;
        logic        mis;
        logic        inv;
        logic        ev;
        logic        et;
        logic [31:0] etgt;
        logic [31:0] eh;
        logic [31:0] em;
        logic [3:0]  eghr;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(
        input logic le, input logic [31:0] lpc,
        input logic up, input logic [31:0] upc, input logic [31:0] utgt,
        input logic utk, input logic [3:0] ughr, input logic mis, input logic inv,
        input logic ev, input logic et, input logic [31:0] etgt,
        input logic [31:0] eh, input logic [31:0] em, input logic [3:0] eghr);
        vec_t v;
        v.le = le; v.lpc = lpc; v.up = up; v.upc = upc; v.utgt = utgt;
        v.utk = utk; v.ughr = ughr; v.mis = mis; v.inv = inv;
        v.ev = ev; v.et = et; v.etgt = etgt; v.eh = eh; v.em = em; v.eghr = eghr;
        return v;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
    endtask

    task automatic idle_inputs();
        lookup_en = 0; lookup_pc = 0; update = 0; update_pc = 0;
        update_target = 0; update_taken = 0; update_ghr = 0;
        mispredicted = 0; invalidate_all = 0;
    endtask

    // Drive one row just after a rising edge, sample mid-cycle.
    task automatic step(input vec_t v, input int row);
        vec_t e;
        @(posedge clk);
        #1;
        lookup_en = v.le; lookup_pc = v.lpc; update = v.up; update_pc = v.upc;
        update_target = v.utgt; update_taken = v.utk; update_ghr = v.ughr;
        mispredicted = v.mis; invalidate_all = v.inv;
        exp_q.push_back(v);
        #3;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", row, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("valid",      row, 32'(valid),           32'(e.ev));
            chk("pred_taken", row, 32'(predicted_taken), 32'(e.et));
            chk("target_pc",  row, target_pc,            e.etgt);
            chk("hit_count",  row, hit_count,            e.eh);
            chk("mis_count",  row, mispredict_count,     e.em);
            chk("lookup_ghr", row, 32'(lookup_ghr),      32'(e.eghr));
        end
    endtask

    initial begin
        idle_inputs();
        lookup_pc = 32'h100;
        rst = 1'b0;
        #12;
        // Outputs during reset
        chk("rst_valid",  -1, 32'(valid), 0);
        chk("rst_taken",  -1, 32'(predicted_taken), 0);
        chk("rst_target", -1, target_pc, 0);
        chk("rst_hits",   -1, hit_count, 0);
        chk("rst_mis",    -1, mispredict_count, 0);
        chk("rst_ghr",    -1, 32'(lookup_ghr), 0);
        @(negedge clk);
        rst = 1'b1;

`ifdef BPU_GSHARE_EN
        //          le lpc      up upc       utgt     tk ghr mis inv  ev et etgt   eh em eghr
        tbl.push_back(mk(1, 32'h100, 1, 32'h100,  32'h200, 1, 0, 0, 0,  0, 0, 0,       0, 0, 4'h0));
        tbl.push_back(mk(1, 32'h100, 0, 0,        0,       0, 0, 0, 0,  0, 0, 0,       0, 0, 4'h1));
        tbl.push_back(mk(1, 32'h100, 1, 32'h100,  32'h220, 1, 1, 0, 0,  0, 0, 0,       0, 0, 4'h1));
        tbl.push_back(mk(1, 32'h100, 1, 32'h1000, 32'h0,   0, 0, 0, 0,  0, 0, 0,       0, 0, 4'h3));
        tbl.push_back(mk(1, 32'h100, 1, 32'h1000, 32'h0,   0, 0, 0, 0,  0, 0, 0,       0, 0, 4'h6));
        tbl.push_back(mk(1, 32'h100, 1, 32'h1000, 32'h0,   0, 0, 0, 0,  0, 0, 0,       0, 0, 4'hC));
        tbl.push_back(mk(1, 32'h100, 1, 32'h1000, 32'h900, 1, 0, 0, 0,  0, 0, 0,       0, 0, 4'h8));
        tbl.push_back(mk(1, 32'h100, 0, 0,        0,       0, 0, 0, 0,  1, 1, 32'h220, 0, 0, 4'h1));
        tbl.push_back(mk(0, 32'h100, 0, 0,        0,       0, 0, 0, 0,  1, 1, 32'h220, 1, 0, 4'h1));
`else
        //          le lpc      up upc      utgt     tk ghr mis inv  ev et etgt    eh em
        tbl.push_back(mk(0, 32'h100, 0, 0,       0,       0, 0, 0, 0,  0, 0, 0,       0, 0, 0));
        tbl.push_back(mk(1, 32'h100, 1, 32'h100, 32'h200, 1, 0, 0, 0,  0, 0, 0,       0, 0, 0));
        tbl.push_back(mk(1, 32'h100, 0, 0,       0,       0, 0, 0, 0,  1, 1, 32'h200, 0, 0, 0));
        tbl.push_back(mk(1, 32'h100, 1, 32'h100, 32'h0,   0, 0, 1, 0,  1, 1, 32'h200, 1, 0, 0));
        tbl.push_back(mk(0, 32'h100, 1, 32'h100, 32'h0,   0, 0, 0, 0,  1, 0, 32'h200, 2, 1, 0));
        tbl.push_back(mk(0, 32'h100, 1, 32'h100, 32'h0,   0, 0, 0, 0,  1, 0, 32'h200, 2, 1, 0));
        tbl.push_back(mk(0, 32'h100, 1, 32'h100, 32'h204, 1, 0, 0, 0,  1, 0, 32'h200, 2, 1, 0));
        tbl.push_back(mk(0, 32'h100, 1, 32'h100, 32'h208, 1, 0, 0, 0,  1, 0, 32'h204, 2, 1, 0));
        tbl.push_back(mk(0, 32'h100, 1, 32'h100, 32'h208, 1, 0, 0, 0,  1, 1, 32'h208, 2, 1, 0));
        tbl.push_back(mk(0, 32'h100, 1, 32'h100, 32'h208, 1, 0, 0, 0,  1, 1, 32'h208, 2, 1, 0));
        tbl.push_back(mk(0, 32'h100, 1, 32'h100, 32'h999, 0, 0, 0, 0,  1, 1, 32'h208, 2, 1, 0));
        tbl.push_back(mk(0, 32'h100, 0, 0,       0,       0, 0, 0, 0,  1, 1, 32'h208, 2, 1, 0));
        tbl.push_back(mk(1, 32'h140, 1, 32'h140, 32'h300, 0, 0, 1, 0,  0, 0, 0,       2, 1, 0));
        tbl.push_back(mk(0, 32'h100, 0, 0,       0,       0, 0, 0, 0,  1, 1, 32'h208, 2, 2, 0));
        tbl.push_back(mk(0, 32'h140, 1, 32'h140, 32'h300, 1, 0, 0, 0,  0, 0, 0,       2, 2, 0));
        tbl.push_back(mk(1, 32'h140, 0, 0,       0,       0, 0, 0, 0,  1, 1, 32'h300, 2, 2, 0));
        tbl.push_back(mk(0, 32'h100, 0, 0,       0,       0, 0, 0, 0,  0, 0, 0,       3, 2, 0));
        tbl.push_back(mk(1, 32'h140, 1, 32'h180, 32'h400, 1, 0, 0, 1,  1, 1, 32'h300, 3, 2, 0));
        tbl.push_back(mk(1, 32'h180, 0, 0,       0,       0, 0, 0, 0,  0, 0, 0,       4, 2, 0));
        tbl.push_back(mk(1, 32'h140, 0, 0,       0,       0, 0, 0, 0,  0, 0, 0,       4, 2, 0));
        tbl.push_back(mk(1, 32'h100, 0, 0,       0,       0, 0, 0, 0,  0, 0, 0,       4, 2, 0));
`endif

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], i);

        // Reset asserted while an update is on the bus: the update is lost
        // and everything reads zero, asynchronously and after release.
        @(posedge clk);
        #1;
        lookup_en = 1; lookup_pc = 32'h100; update = 1; update_pc = 32'h100;
        update_target = 32'h500; update_taken = 1; mispredicted = 1;
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_hits",  100, hit_count, 0);
        chk("async_rst_mis",   100, mispredict_count, 0);
        chk("async_rst_valid", 100, 32'(valid), 0);
        @(posedge clk);
        #1;
        chk("rst_hold_valid",  101, 32'(valid), 0);
        chk("rst_hold_target", 101, target_pc, 0);
        chk("rst_hold_mis",    101, mispredict_count, 0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        step(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0), 102);
        step(mk(0, 32'h100, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0), 103);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
